// File: rtl/stream_pkg.sv
// Shared widths and fetch-state encoding for the sample streamer.
package stream_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/sample_streamer_if.sv
// Read port between the streamer (master) and the RAM controller (slave).
interface sample_streamer_if;
    import stream_pkg::*;

    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_valid;
    logic [SAMPLE_W-1:0] rd_data;

    modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
    modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);

endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with show-ahead head output and a single-cycle flush.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sample_streamer.sv
// Streams a RAM region into a sample FIFO and plays one word per sample tick.
//   IDLE | waiting for a play rising edge
//   REQ  | issue one read once the FIFO has room and nothing is outstanding
//   WAIT | read outstanding, push the word on rd_valid
//   DONE | region fetched, wait for the FIFO to drain
module sample_streamer
    import stream_pkg::*;
#(
    parameter int SAMPLE_DIV = 2268,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 play,
    input  logic                 loop,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    length,
    sample_streamer_if.master    ram,
    output logic [SAMPLE_W-1:0]  sample,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 underrun
);
    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [TICK_W-1:0]   tick_cnt_q;
    logic [TICK_W-1:0]   tick_cnt_d;
    logic                tick;

    fetch_state_t        state_q;
    logic                play_q;
    logic                busy_q;
    logic                underrun_q;
    logic                rd_req_q;
    logic                drop_q;
    logic                sample_valid_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   remain_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   len_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [SAMPLE_W-1:0] fifo_head;
    logic                flush;
    logic                push;
    logic                pop;
    logic                room;
    logic                drains;

    assign tick       = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // drop_q marks a read abandoned by an abort; it still counts as outstanding.
    assign flush  = ~play & (state_q != ST_IDLE);
    assign push   = (state_q == ST_WAIT) & play & ram.rd_valid & ~drop_q;
    assign pop    = tick & ~fifo_empty & ~flush;
    assign room   = ~fifo_full & ~drop_q;
    assign drains = fifo_empty | (pop & (fifo_count == CNT_W'(1)));

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (ram.rd_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            play_q         <= 1'b0;
            busy_q         <= 1'b0;
            underrun_q     <= 1'b0;
            rd_req_q       <= 1'b0;
            drop_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_q       <= '0;
            addr_q         <= '0;
            remain_q       <= '0;
            base_q         <= '0;
            len_q          <= '0;
        end else begin
            play_q         <= play;
            rd_req_q       <= 1'b0;
            sample_valid_q <= pop;
            if (pop) begin
                sample_q <= fifo_head;
            end
            if (tick && fifo_empty && busy_q) begin
                underrun_q <= 1'b1;
            end
            if (ram.rd_valid) begin
                drop_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (play && !play_q && length != '0) begin
                        base_q     <= base_addr;
                        len_q      <= length;
                        addr_q     <= base_addr;
                        remain_q   <= length;
                        underrun_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!play) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (room) begin
                        rd_req_q <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!play) begin
                        drop_q  <= ~ram.rd_valid;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (ram.rd_valid) begin
                        if (remain_q == ADDR_W'(1)) begin
                            if (loop) begin
                                addr_q   <= base_q;
                                remain_q <= len_q;
                                state_q  <= ST_REQ;
                            end else begin
                                addr_q   <= addr_q + ADDR_W'(1);
                                remain_q <= '0;
                                state_q  <= ST_DONE;
                            end
                        end else begin
                            addr_q   <= addr_q + ADDR_W'(1);
                            remain_q <= remain_q - ADDR_W'(1);
                            state_q  <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    if (!play || drains) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram.rd_req   = rd_req_q;
    assign ram.rd_addr  = addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Self-checking bench: RAM responder, address/sample scoreboards and directed plus random regions.
module tb_sample_streamer;
    import stream_pkg::*;

    localparam int DIV   = 50;
    localparam int DEPTH = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                play;
    logic                loop;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   length;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                busy;
    logic                underrun;

    sample_streamer_if ram ();

    sample_streamer #(
        .SAMPLE_DIV (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .play         (play),
        .loop         (loop),
        .base_addr    (base_addr),
        .length       (length),
        .ram          (ram),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int                n_chk = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                req_idx = 0;
    int                smp_idx = 0;
    int                sv_cnt = 0;
    int                rq_cnt = 0;
    int                ram_lat = 2;
    logic              ram_hold = 1'b0;
    logic              ram_pend = 1'b0;
    logic [ADDR_W-1:0] cur_base = '0;
    logic [ADDR_W-1:0] cur_len = '0;
    logic              cur_loop = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Region walk: n-th word address of the current playback request.
    function automatic logic [ADDR_W-1:0] exp_addr(input int idx);
        if (cur_len == '0) return cur_base;
        if (cur_loop) return cur_base + ADDR_W'(idx % int'(cur_len));
        return cur_base + ADDR_W'(idx);
    endfunction

    function automatic logic [SAMPLE_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return a[15:0] + 16'h0100;
    endfunction

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        logic [ADDR_W-1:0] a;
        ram.rd_valid = 1'b0;
        ram.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (ram.rd_req && !ram_hold) begin
                a        = ram.rd_addr;
                ram_pend = 1'b1;
                repeat (ram_lat - 1) @(negedge clk);
                ram.rd_valid = 1'b1;
                ram.rd_data  = ram_word(a);
                @(negedge clk);
                ram.rd_valid = 1'b0;
                ram_pend     = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ram.rd_req) begin
                rq_cnt++;
                check_val("rd_addr", 32'(ram.rd_addr), 32'(exp_addr(req_idx)));
                req_idx++;
            end
            if (sample_valid) begin
                sv_cnt++;
                check_val("sample", 32'(sample), 32'(ram_word(exp_addr(smp_idx))));
                check_val("sv_phase", 32'(cyc % DIV), 32'(0));
                smp_idx++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start just after a tick so the first word lands before the next tick.
    task automatic start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l, input logic lp);
        int guard = 0;
        while ((cyc % DIV) != 2 && guard < 2 * DIV) begin
            @(negedge clk);
            guard++;
        end
        cur_base  = b;
        cur_len   = l;
        cur_loop  = lp;
        req_idx   = 0;
        smp_idx   = 0;
        base_addr = b;
        length    = l;
        loop      = lp;
        play      = 1'b1;
    endtask

    task automatic wait_smp(input int n, input int budget);
        int k = 0;
        while (smp_idx < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val("smp_count", 32'(smp_idx), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val("busy_fall", 32'(busy), 32'(0));
    endtask

    task automatic ram_quiet(input int budget);
        int k = 0;
        while (ram_pend && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val("ram_quiet", 32'(ram_pend), 32'(0));
    endtask

    task automatic wait_req(input string tag, input int budget);
        int k = 0;
        while (!ram.rd_req && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, 32'(ram.rd_req), 32'(1));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_rd_req"},   32'(ram.rd_req),   32'(0));
        check_val({pfx, "_rd_addr"},  32'(ram.rd_addr),  32'(0));
        check_val({pfx, "_sample"},   32'(sample),       32'(0));
        check_val({pfx, "_sv"},       32'(sample_valid), 32'(0));
        check_val({pfx, "_busy"},     32'(busy),         32'(0));
        check_val({pfx, "_underrun"}, 32'(underrun),     32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SAMPLE_W-1:0] s0;
        int                  sv0;
        int                  rq0;
        logic                busy_seen;

        rst = 1'b1; play = 1'b0; loop = 1'b0; base_addr = '0; length = '0;
        cycles(3);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Plain region, no loop
        start(23'h10, 23'd4, 1'b0);
        cycles(2);
        check_val("t1_busy_start", 32'(busy), 32'(1));
        wait_smp(4, 6 * DIV);
        wait_idle(20);
        check_val("t1_reqs", 32'(req_idx), 32'(4));
        check_val("t1_underrun", 32'(underrun), 32'(0));
        cycles(2 * DIV);
        check_val("t1_no_extra", 32'(smp_idx), 32'(4));
        play = 1'b0;
        cycles(2);

        // Looping region
        start(23'h10, 23'd3, 1'b1);
        wait_smp(7, 9 * DIV);
        check_val("t2_underrun", 32'(underrun), 32'(0));
        check_val("t2_busy", 32'(busy), 32'(1));
        play = 1'b0;
        cycles(2);
        check_val("t2_abort_busy", 32'(busy), 32'(0));
        ram_quiet(100);

        // Starved FIFO
        ram_lat = 3000;
        s0  = sample;
        sv0 = sv_cnt;
        start(23'h20, 23'd2, 1'b0);
        cycles(DIV);
        check_val("t3_underrun", 32'(underrun), 32'(1));
        check_val("t3_no_sv", 32'(sv_cnt), 32'(sv0));
        check_val("t3_sample_held", 32'(sample), 32'(s0));
        wait_smp(2, 7000);
        wait_idle(20);
        check_val("t3_sticky", 32'(underrun), 32'(1));
        play = 1'b0;
        ram_quiet(100);
        ram_lat = 2;

        // Abort while a read is outstanding
        ram_hold = 1'b1;
        sv0 = sv_cnt;
        start(23'h40, 23'd4, 1'b0);
        wait_req("t4_req_seen", 20);
        check_val("t4_underrun_clr", 32'(underrun), 32'(0));
        play = 1'b0;
        cycles(1);
        check_val("t4_busy", 32'(busy), 32'(0));
        cycles(1);
        ram.rd_valid = 1'b1;
        ram.rd_data  = 16'hDEAD;
        cycles(1);
        ram.rd_valid = 1'b0;
        cycles(2 * DIV);
        check_val("t4_no_sample", 32'(sv_cnt), 32'(sv0));
        check_val("t4_underrun", 32'(underrun), 32'(0));
        ram_hold = 1'b0;

        // Zero length
        rq0 = rq_cnt;
        busy_seen = 1'b0;
        start(23'h100, 23'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        check_val("t5_no_req", 32'(rq_cnt), 32'(rq0));
        check_val("t5_no_busy", 32'(busy_seen), 32'(0));
        play = 1'b0;
        cycles(2);

        // Address wrap
        start(23'h7FFFFE, 23'd3, 1'b0);
        wait_smp(3, 5 * DIV);
        wait_idle(20);
        check_val("t5_wrap_reqs", 32'(req_idx), 32'(3));
        play = 1'b0;
        cycles(2);

        // Random regions
        for (int it = 0; it < 6; it++) begin
            logic [ADDR_W-1:0] b;
            logic [ADDR_W-1:0] l;
            logic              lp;
            int                n;
            b  = ($urandom_range(0, 3) == 0) ? 23'h7FFFFC : ADDR_W'($urandom);
            l  = ADDR_W'($urandom_range(1, 6));
            lp = 1'($urandom_range(0, 1));
            ram_lat = $urandom_range(1, 15);
            n  = lp ? int'(l) * 2 + 1 : int'(l);
            start(b, l, lp);
            wait_smp(n, (n + 3) * DIV);
            check_val("rnd_underrun", 32'(underrun), 32'(0));
            if (!lp) begin
                wait_idle(20);
                check_val("rnd_reqs", 32'(req_idx), 32'(l));
            end
            play = 1'b0;
            cycles(3);
            ram_quiet(100);
        end

        // Reset during an outstanding read
        ram_lat = 200;
        start(23'h50, 23'd4, 1'b0);
        wait_req("t6_req_seen", 20);
        cycles(3);
        rst  = 1'b1;
        play = 1'b0;
        cycles(1);
        check_reset_outputs("t6");
        rst = 1'b0;
        sv0 = sv_cnt;
        ram_quiet(400);
        cycles(2 * DIV);
        check_val("t6_no_push", 32'(sv_cnt), 32'(sv0));
        check_val("t6_busy", 32'(busy), 32'(0));
        check_val("t6_underrun", 32'(underrun), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, 2268, clk cycles per sample tick (100 MHz / 44.1 kHz).
REQ-002 SHALL have parameter FIFO_DEPTH, 8, sample buffer entries, power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port play  input  1  level; high starts or continues playback, low aborts.
REQ-006 SHALL have port loop  input  1  level; sampled at end of region: 1 restarts at base_addr.
REQ-007 SHALL have port base_addr  input  23  first word address; captured on the play rising edge.
REQ-008 SHALL have port length  input  23  word count; captured with base_addr.
REQ-009 SHALL have port rd_req  output  1  one-cycle read request to the RAM controller.
REQ-010 SHALL have port rd_addr  output  23  word address; valid while rd_req is high.
REQ-011 SHALL have port rd_valid  input  1  one-cycle strobe; rd_data valid in the same cycle.
REQ-012 SHALL have port rd_data  input  16  read word from the RAM controller.
REQ-013 SHALL have port sample  output  16  current audio sample; holds between ticks.
REQ-014 SHALL have port sample_valid  output  1  one-cycle pulse when sample updates.
REQ-015 SHALL have port busy  output  1  high from play capture until the region is drained or aborted.
REQ-016 SHALL have port underrun  output  1  sticky; set when a tick finds the FIFO empty while busy.

Function
REQ-017 SHALL use a free-running tick counter 0..SAMPLE_DIV-1, pulsing tick on the wrap, whether or not busy is high.
REQ-018 SHALL implement fetch FSM states IDLE, REQ, WAIT, DONE.
REQ-019 IDLE->REQ on play rising edge with length!=0; SHALL capture base_addr/length, clear underrun and assert busy; with length==0 SHALL stay IDLE with busy low.
REQ-020 REQ SHALL pulse rd_req for exactly one cycle only when fifo_count + outstanding < FIFO_DEPTH, then enter WAIT.
REQ-021 SHALL allow at most one outstanding read at any time.
REQ-022 WAIT SHALL push rd_data into the FIFO on rd_valid, increment the address and decrement the remaining count.
REQ-023 When the remaining count reaches 0: with loop=1, SHALL reload base_addr/length and go to REQ; with loop=0, SHALL go to DONE.
REQ-024 DONE SHALL drop busy and return to IDLE in the cycle the FIFO becomes empty.
REQ-025 On tick with the FIFO non-empty, SHALL pop the head into sample and pulse sample_valid in the cycle after tick (latency 1).
REQ-026 On tick with the FIFO empty and busy high, SHALL hold sample, keep sample_valid low and set underrun.
REQ-027 Simultaneous push and pop SHALL leave fifo_count unchanged and lose no data.
REQ-028 If play falls while in WAIT, SHALL discard the pending rd_valid word, then flush the FIFO and go to IDLE.
REQ-029 If play falls in any other state, SHALL flush the FIFO and go to IDLE on the next cycle.
REQ-030 SHALL not re-trigger playback while busy, even on another play rising edge.
REQ-031 Address arithmetic SHALL be 23-bit unsigned, wrapping from 0x7FFFFF to 0x000000.

Reset
REQ-032 rst SHALL force: FSM=IDLE, rd_req=0, rd_addr=0, sample=0, sample_valid=0, busy=0, underrun=0, FIFO empty, tick counter=0.
REQ-033 rst mid-transfer SHALL drop any outstanding read; a later rd_valid SHALL be ignored.

Structure
REQ-034 Package stream_pkg SHALL hold the FSM state enum and the constants SAMPLE_W=16 and ADDR_W=23.
REQ-035 The FIFO SHALL be a sub-module sample_fifo: synchronous, with push, pop, full, empty and count ports.

Verification
REQ-036 Test 1: base=0x10, length=4, loop=0, RAM model returning addr+0x100 -> samples 0x110..0x113 on four consecutive ticks, then busy falls.
REQ-037 Test 2: length=3, loop=1 -> samples 0x110,0x111,0x112,0x110,0x111... with no underrun.
REQ-038 Test 3: RAM latency 3000 cycles -> underrun=1, sample held, no sample_valid on the starved tick.
REQ-039 Test 4: play dropped while in WAIT -> late rd_valid ignored, FIFO empty, IDLE within 2 cycles.
REQ-040 Test 5: length=0 -> no rd_req and busy stays 0; base=0x7FFFFE, length=3 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000.
REQ-041 Test 6: rst asserted mid-WAIT -> all outputs at reset values next cycle; subsequent rd_valid causes no push.
